// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the bit-serial ALU sequencer.
//   alu_op_e   - MIPS ALU control codes accepted on req_op
//   state_e    - sequencer states
//   OP_*       - 2-bit Operation select of the alu_block slice
//   is_valid_op - true for the six supported req_op codes
package alu_seq_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_SUM  = 2'b10;
   localparam logic [1:0] OP_LESS = 2'b11;

   function automatic logic is_valid_op(input logic [3:0] op);
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: is_valid_op = 1'b1;
         default:                                            is_valid_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_block.sv
// alu_block: classic 1-bit MIPS ALU slice (purely combinational).
//   a, b        operand bits
//   a_invert    invert a before the logic/adder
//   b_invert    invert b before the logic/adder
//   carry_in    adder carry input
//   operation   00 AND, 01 OR, 10 SUM, 11 LESS pass-through
//   less        value routed to result when operation = 11
//   result      selected output bit
//   carry_out   adder carry output
module alu_block
   import alu_seq_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       a_invert,
   input  logic       b_invert,
   input  logic       carry_in,
   input  logic [1:0] operation,
   input  logic       less,
   output logic       result,
   output logic       carry_out
);

   logic a_m, b_m, sum;

   assign a_m       = a ^ a_invert;
   assign b_m       = b ^ b_invert;
   assign sum       = a_m ^ b_m ^ carry_in;
   assign carry_out = (a_m & b_m) | (a_m & carry_in) | (b_m & carry_in);

   always_comb begin
      result = 1'b0;
      case (operation)
         OP_AND:  result = a_m & b_m;
         OP_OR:   result = a_m | b_m;
         OP_SUM:  result = sum;
         OP_LESS: result = less;
         default: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: bit-serial sequencer computing a WIDTH-bit MIPS ALU op with
// one alu_block slice, one bit per cycle, LSB first.
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op, req_a, req_b       ALU control code and operands
//   resp_valid/resp_ready      response handshake (valid held in DONE)
//   resp_result, resp_zero     result and result==0 flag
//   resp_overflow              signed ADD/SUB overflow (ALU_SEQ_OVF_EN only)
// Optional feature macro: ALU_SEQ_OVF_EN builds the resp_overflow port.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_result,
`ifdef ALU_SEQ_OVF_EN
   output logic             resp_overflow,
`endif
   output logic             resp_zero
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [3:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, zacc_q, zero_q;
   logic             last;

   logic             a_inv, b_inv, slice_res, slice_cout;
   logic [1:0]       slice_opn;
   logic             ovf, set_bit;
   logic [WIDTH-1:0] shifted, final_res;
   logic             final_zero;

   assign req_ready   = (state_q == S_IDLE);
   assign resp_valid  = (state_q == S_DONE);
   assign resp_result = res_q;
   assign resp_zero   = zero_q;
   assign last        = (cnt_q == CW'(WIDTH - 1));

   // ---------------------------------------------------------------
   // Slice control decode. SLT runs as a subtract; the set bit is
   // derived here from the MSB so the slice's LESS path is never used.
   // ---------------------------------------------------------------
   always_comb begin
      a_inv     = 1'b0;
      b_inv     = 1'b0;
      slice_opn = OP_AND;
      case (op_q)
         ALU_AND: slice_opn = OP_AND;
         ALU_OR:  slice_opn = OP_OR;
         ALU_ADD: slice_opn = OP_SUM;
         ALU_SUB, ALU_SLT: begin
            slice_opn = OP_SUM;
            b_inv     = 1'b1;
         end
         ALU_NOR: begin
            a_inv     = 1'b1;
            b_inv     = 1'b1;
            slice_opn = OP_AND;
         end
         default: slice_opn = OP_AND;
      endcase
   end

   alu_block u_slice (
      .a         (a_q[0]),
      .b         (b_q[0]),
      .a_invert  (a_inv),
      .b_invert  (b_inv),
      .carry_in  (carry_q),
      .operation (slice_opn),
      .less      (1'b0),
      .result    (slice_res),
      .carry_out (slice_cout)
   );

   // Only meaningful on the last bit, where carry_q is the carry into
   // the MSB and slice_res is the MSB of the sum.
   assign ovf     = carry_q ^ slice_cout;
   assign set_bit = slice_res ^ ovf;
   assign shifted = {slice_res, res_q[WIDTH-1:1]};

   always_comb begin
      final_res  = shifted;
      final_zero = ~(zacc_q | slice_res);
      if (!is_valid_op(op_q)) begin
         final_res  = '0;
         final_zero = 1'b1;
      end else if (op_q == ALU_SLT) begin
         final_res  = {{(WIDTH-1){1'b0}}, set_bit};
         final_zero = ~set_bit;
      end
   end

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_valid)  state_d = S_RUN;
         S_RUN:   if (last)       state_d = S_DONE;
         S_DONE:  if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath: operand shift registers, carry chain, result shifter
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zacc_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  a_q     <= req_a;
                  b_q     <= req_b;
                  op_q    <= req_op;
                  cnt_q   <= '0;
                  res_q   <= '0;
                  zacc_q  <= 1'b0;
                  carry_q <= (req_op == ALU_SUB) || (req_op == ALU_SLT);
               end
            end
            S_RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= slice_cout;
               zacc_q  <= zacc_q | slice_res;
               if (last) begin
                  res_q  <= final_res;
                  zero_q <= final_zero;
               end else begin
                  res_q  <= shifted;
                  cnt_q  <= cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (state_q == S_RUN && last)
         ovf_q <= ((op_q == ALU_ADD) || (op_q == ALU_SUB)) ? ovf : 1'b0;
   end

   assign resp_overflow = ovf_q;
`endif

endmodule
